pwr_cg_enable_ctrl: RTL and testbench



---
 rtl/pwr_cg_pkg.sv | 19 +
 rtl/pwr_cg_downcnt.sv | 24 ++
 rtl/pwr_cg_enable_ctrl.sv | 110 +++++++++++
 tb/tb_pwr_cg_enable_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pwr_cg_pkg.sv
// Shared types and defaults for the activity-based clock-gate enable controller.
package pwr_cg_pkg;

  typedef enum logic [1:0] {
    CG_ACTIVE = 2'd0,
    CG_GATED  = 2'd1,
    CG_WAKE   = 2'd2
  } cg_state_e;

  localparam int unsigned CG_IDLE_DEF  = 16;
  localparam int unsigned CG_WAKE_DEF  = 2;
  localparam int unsigned CG_CNT_W_DEF = 8;

  // True when val is nonzero and representable in cnt_w bits.
  function automatic bit cg_cnt_fits(int unsigned val, int unsigned cnt_w);
    return (val >= 1) && ($clog2(val + 1) <= cnt_w);
  endfunction

endpackage

// File: rtl/pwr_cg_downcnt.sv
// Loadable down-counter that holds at zero; shared by the idle and wake phases.
module pwr_cg_downcnt #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                     cnt <= RST_VAL;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pwr_cg_enable_ctrl.sv
// Clock-gate enable controller: gates after an idle window, wakes with a settle delay.
// Optional PWR_CG_STATS_EN adds a saturating gated-cycle counter with synchronous clear.
module pwr_cg_enable_ctrl
  import pwr_cg_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = CG_IDLE_DEF,
  parameter int unsigned WAKE_CYCLES = CG_WAKE_DEF,
  parameter int unsigned CNT_W       = CG_CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        activity,
  input  logic        force_on,
`ifdef PWR_CG_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] gated_cycles,
`endif
  output logic        module_enable,
  output logic        ready,
  output logic        gated,
  output logic        wake_evt
);

  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);

  if (!cg_cnt_fits(IDLE_CYCLES, CNT_W) || !cg_cnt_fits(WAKE_CYCLES, CNT_W)) begin : g_bad_cfg
    $error("pwr_cg_enable_ctrl: IDLE_CYCLES/WAKE_CYCLES out of range for CNT_W");
  end

  cg_state_e        state, state_nxt;
  logic             wake_req;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;

  assign wake_req = activity | force_on;

  // Reload on any request takes priority over idle expiry, so force_on wins a tie.
  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_ld_val = IDLE_LD;
    case (state)
      CG_ACTIVE: begin
        if (wake_req)      cnt_load  = 1'b1;
        else if (cnt_zero) state_nxt = CG_GATED;
        else               cnt_dec   = 1'b1;
      end
      CG_GATED: begin
        if (wake_req) begin
          state_nxt  = CG_WAKE;
          cnt_load   = 1'b1;
          cnt_ld_val = WAKE_LD;
        end
      end
      CG_WAKE: begin
        if (cnt_zero) begin
          state_nxt = CG_ACTIVE;
          cnt_load  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_nxt = CG_ACTIVE;
        cnt_load  = 1'b1;
      end
    endcase
  end

  pwr_cg_downcnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (IDLE_LD)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Outputs decode the next state so the gate enable only moves at posedge clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CG_ACTIVE;
      module_enable <= 1'b1;
      ready         <= 1'b1;
      gated         <= 1'b0;
      wake_evt      <= 1'b0;
    end else begin
      state         <= state_nxt;
      module_enable <= (state_nxt != CG_GATED);
      ready         <= (state_nxt == CG_ACTIVE);
      gated         <= (state_nxt == CG_GATED);
      wake_evt      <= (state == CG_GATED) && (state_nxt == CG_WAKE);
    end
  end

`ifdef PWR_CG_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clr)
      gated_cycles <= '0;
    else if (state == CG_GATED && gated_cycles != 32'hFFFF_FFFF)
      gated_cycles <= gated_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pwr_cg_enable_ctrl.sv
// Bench for pwr_cg_enable_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_pwr_cg_enable_ctrl;
  import pwr_cg_pkg::*;

  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic activity = 1'b0;
  logic force_on = 1'b0;
  logic module_enable, ready, gated, wake_evt;
`ifdef PWR_CG_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] gated_cycles;
  longint      m_gc;
`endif

  int checks = 0;
  int errors = 0;

  // Model: gated flag, remaining wake cycles, run length of consecutive idle cycles.
  bit m_gated;
  int m_wake;
  int m_idle;
  bit m_evt;

  always #5 clk = ~clk;

  pwr_cg_enable_ctrl #(
    .IDLE_CYCLES (IDLE),
    .WAKE_CYCLES (WAKE),
    .CNT_W       (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .activity      (activity),
    .force_on      (force_on),
`ifdef PWR_CG_STATS_EN
    .stats_clr     (stats_clr),
    .gated_cycles  (gated_cycles),
`endif
    .module_enable (module_enable),
    .ready         (ready),
    .gated         (gated),
    .wake_evt      (wake_evt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit req;
    req   = activity || force_on;
    m_evt = 1'b0;
`ifdef PWR_CG_STATS_EN
    if (rst || stats_clr)                    m_gc = 0;
    else if (m_gated && m_gc < 64'hFFFF_FFFF) m_gc++;
`endif
    if (rst) begin
      m_gated = 1'b0; m_wake = 0; m_idle = 0;
    end else if (m_gated) begin
      if (req) begin
        m_gated = 1'b0; m_wake = WAKE; m_evt = 1'b1;
      end
    end else if (m_wake > 0) begin
      m_wake--;
      if (m_wake == 0) m_idle = 0;
    end else if (req) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == IDLE) m_gated = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("module_enable", 32'(module_enable), 32'(!m_gated));
    chk("ready",         32'(ready),         32'(!m_gated && m_wake == 0));
    chk("gated",         32'(gated),         32'(m_gated));
    chk("wake_evt",      32'(wake_evt),      32'(m_evt));
`ifdef PWR_CG_STATS_EN
    chk("gated_cycles",  gated_cycles,       32'(m_gc));
`endif
  endtask

  task automatic run_until_gated(output int n);
    n = 0;
    while (!gated && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  dropped;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cnt", 32'(dut.u_cnt.cnt), 32'(IDLE - 1));
    chk("rst_state", 32'(dut.state), 32'(CG_ACTIVE));
    rst = 1'b0;

    // Idle from reset: gate after exactly IDLE cycles
    run_until_gated(n);
    chk("gate_after_rst", 32'(n), 32'(IDLE));

    // Activity pulse in the idle window restarts the count
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    activity = 1'b1; tick(); activity = 1'b0;
    run_until_gated(n);
    chk("gate_after_pulse", 32'(n), 32'(IDLE));

    // One-cycle activity in GATED: wake pulse, enable at +1, ready at +1+WAKE
    activity = 1'b1; tick(); activity = 1'b0;
    chk("wake_evt_pulse", 32'(wake_evt), 32'd1);
    chk("wake_enable", 32'(module_enable), 32'd1);
    chk("wake_ready_low", 32'(ready), 32'd0);
    n = 1;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_latency", 32'(n), 32'(1 + WAKE));
    run_until_gated(n);
    chk("regate_after_wake", 32'(n), 32'(IDLE));

    // force_on held: never gated; gating resumes IDLE cycles after release
    force_on = 1'b1;
    dropped  = 1'b0;
    repeat (100) begin
      tick();
      if (!module_enable) dropped = 1'b1;
    end
    chk("force_on_hold", 32'(dropped), 32'd0);
    force_on = 1'b0;
    run_until_gated(n);
    chk("gate_after_force", 32'(n), 32'(IDLE));

    // Reset during the second WAKE cycle
    activity = 1'b1; tick(); activity = 1'b0;
    tick();
    chk("in_wake", 32'(dut.state), 32'(CG_WAKE));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("wake_rst_state", 32'(dut.state), 32'(CG_ACTIVE));
    chk("wake_rst_enable", 32'(module_enable), 32'd1);
    chk("wake_rst_ready", 32'(ready), 32'd1);
    chk("wake_rst_cnt", 32'(dut.u_cnt.cnt), 32'(IDLE - 1));

`ifdef PWR_CG_STATS_EN
    run_until_gated(n);
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    chk("stats_clr0", gated_cycles, 32'd0);
    repeat (40) tick();
    chk("stats_40", gated_cycles, 32'd40);
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    chk("stats_clr1", gated_cycles, 32'd0);
    tick();
    chk("stats_resume", gated_cycles, 32'd1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      activity = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) == 0) force_on = ~force_on;
      rst = ($urandom_range(0, 999) == 0);
`ifdef PWR_CG_STATS_EN
      stats_clr = ($urandom_range(0, 199) == 0);
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
